// File: rtl/lcd12864_pkg.sv
// Shared types and constants for the ST7920 128x64 graphic-mode refresh controller.
package lcd12864_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_SET_Y,
        ST_SET_X,
        ST_DATA,
        ST_DONE
    } state_e;

    // ST7920 command bytes used during init and addressing
    localparam logic [7:0] CMD_BASIC   = 8'h30;
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_EXT     = 8'h34;
    localparam logic [7:0] CMD_GFX_ON  = 8'h36;
    localparam logic [7:0] CMD_ADDR    = 8'h80;

    // Panel / framebuffer geometry
    localparam int GD_LINES          = 32;
    localparam int GD_BYTES_PER_LINE = 32;
    localparam int FB_BYTES          = 1024;

    // Slot index constants shared by the init and data phases
    localparam logic [4:0] IDX_INIT_LAST = 5'd6;
    localparam logic [4:0] IDX_CLR       = 5'd3;
    localparam logic [4:0] IDX_DATA_LAST = 5'(GD_BYTES_PER_LINE - 1);
    localparam logic [4:0] LINE_MAX      = 5'(GD_LINES - 1);

    // Init command sequence, indexed by slot number 0..6
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: init_cmd = CMD_BASIC;
            3'd2:       init_cmd = CMD_DISP_ON;
            3'd3:       init_cmd = CMD_CLEAR;
            3'd4:       init_cmd = CMD_ENTRY;
            3'd5:       init_cmd = CMD_EXT;
            default:    init_cmd = CMD_GFX_ON;
        endcase
    endfunction

endpackage

// File: rtl/lcd12864_bus_slot.sv
// Bus slot timer: a slot begins the cycle after `go`, lasts CMD_CYCLES
// (or CLR_CYCLES when `long_slot`), and produces a registered lcd_en pulse
// from count EN_SETUP for EN_WIDTH cycles. `slot_end` marks the last cycle.
module lcd12864_bus_slot #(
    parameter int CMD_CYCLES = 3600,
    parameter int EN_SETUP   = 4,
    parameter int EN_WIDTH   = 25,
    parameter int CLR_CYCLES = 80000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    input  logic long_slot,
    output logic slot_end,
    output logic lcd_en
);
    localparam int MAXC = (CLR_CYCLES > CMD_CYCLES) ? CLR_CYCLES : CMD_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] EN_ON    = CW'(EN_SETUP);
    localparam logic [CW-1:0] EN_OFF   = CW'(EN_SETUP + EN_WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic          long_q, long_d;
    logic          en_q, en_d;

    assign slot_end = active_q && (cnt_q == (long_q ? CLR_LAST : CMD_LAST));
    assign lcd_en   = en_q;

    // Next slot count; enable is decoded from the next count so it is glitch-free
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        long_d   = long_q;
        if (go) begin
            cnt_d    = '0;
            active_d = 1'b1;
            long_d   = long_slot;
        end else if (slot_end) begin
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (active_q) begin
            cnt_d = cnt_q + 1'b1;
        end
        en_d = active_d && (cnt_d >= EN_ON) && (cnt_d < EN_OFF);
    end

    // Slot timer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            long_q   <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            long_q   <= long_d;
            en_q     <= en_d;
        end
    end

endmodule

// File: rtl/lcd12864_gfx_refresh.sv
// ST7920 128x64 graphic-mode controller (8-bit parallel, write-only).
// Power-on wait, init sequence, then framebuffer -> GDRAM copy per line range.
// Optional build macro LCD12864_AUTO_REFRESH_EN: continuous full-screen refresh.
module lcd12864_gfx_refresh
    import lcd12864_pkg::*;
#(
    parameter int CMD_CYCLES = 3600,
    parameter int EN_SETUP   = 4,
    parameter int EN_WIDTH   = 25,
    parameter int CLR_CYCLES = 80000,
    parameter int PWR_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] line_first,
    input  logic [4:0] line_last,
    output logic       busy,
    output logic       init_done,
    output logic       frame_done,
    output logic       fb_rd_en,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_dat
);
    localparam int PW = $clog2(PWR_CYCLES + 1);
    localparam logic [PW-1:0] PWR_LAST = PW'(PWR_CYCLES - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [4:0]    idx_q, idx_d;
    logic [4:0]    line_q, line_d;
    logic [4:0]    last_q, last_d;
    logic          rs_q, rd_en_q, rd_dly_q, init_done_q, fdone_q;
    logic [7:0]    dat_q;
    logic [9:0]    addr_q;

    logic          go, go_long, go_rs, go_rd;
    logic [7:0]    go_cmd;
    logic [9:0]    go_addr;
    logic          launch;
    logic [4:0]    launch_y, launch_last;
    logic          init_set, fdone_set;
    logic          slot_end;

    lcd12864_bus_slot #(
        .CMD_CYCLES(CMD_CYCLES),
        .EN_SETUP  (EN_SETUP),
        .EN_WIDTH  (EN_WIDTH),
        .CLR_CYCLES(CLR_CYCLES)
    ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .long_slot(go_long),
        .slot_end (slot_end),
        .lcd_en   (lcd_en)
    );

    assign init_done  = init_done_q;
    assign frame_done = fdone_q;
    assign fb_rd_en   = rd_en_q;
    assign fb_addr    = addr_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_dat    = dat_q;

`ifdef LCD12864_AUTO_REFRESH_EN
    logic unused_auto;
    assign unused_auto = ^{start, line_first, line_last};
    assign busy = 1'b1;
`else
    assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
`endif

    // Sequencer: each state owns the slot currently on the bus; the next slot is
    // launched in the slot_end cycle so slots run back-to-back with no gap
    always_comb begin
        state_d     = state_q;
        pwr_cnt_d   = pwr_cnt_q;
        idx_d       = idx_q;
        line_d      = line_q;
        last_d      = last_q;
        go          = 1'b0;
        go_long     = 1'b0;
        go_rs       = 1'b0;
        go_rd       = 1'b0;
        go_cmd      = '0;
        go_addr     = '0;
        launch      = 1'b0;
        launch_y    = '0;
        launch_last = '0;
        init_set    = 1'b0;
        fdone_set   = 1'b0;
        case (state_q)
            ST_PWR_WAIT: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    go      = 1'b1;
                    go_cmd  = init_cmd(3'd0);
                    idx_d   = '0;
                    state_d = ST_INIT;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            ST_INIT: begin
                if (slot_end) begin
                    if (idx_q == IDX_INIT_LAST) begin
                        init_set = 1'b1;
`ifdef LCD12864_AUTO_REFRESH_EN
                        launch      = 1'b1;
                        launch_y    = '0;
                        launch_last = LINE_MAX;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        go      = 1'b1;
                        go_cmd  = init_cmd(idx_d[2:0]);
                        go_long = (idx_d == IDX_CLR);
                    end
                end
            end
            ST_IDLE: begin
`ifndef LCD12864_AUTO_REFRESH_EN
                if (start) begin
                    if (line_first > line_last) begin
                        fdone_set = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        launch      = 1'b1;
                        launch_y    = line_first;
                        launch_last = line_last;
                    end
                end
`endif
            end
            ST_SET_Y: begin
                if (slot_end) begin
                    go      = 1'b1;
                    go_cmd  = CMD_ADDR;
                    state_d = ST_SET_X;
                end
            end
            ST_SET_X: begin
                if (slot_end) begin
                    go      = 1'b1;
                    go_rs   = 1'b1;
                    go_rd   = 1'b1;
                    idx_d   = '0;
                    go_addr = {1'b0, line_q, 4'h0};
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (slot_end) begin
                    if (idx_q == IDX_DATA_LAST) begin
                        // Compare before increment so line 31 never wraps
                        if (line_q == last_q) begin
                            fdone_set = 1'b1;
`ifdef LCD12864_AUTO_REFRESH_EN
                            launch      = 1'b1;
                            launch_y    = '0;
                            launch_last = LINE_MAX;
`else
                            state_d = ST_DONE;
`endif
                        end else begin
                            launch      = 1'b1;
                            launch_y    = line_q + 1'b1;
                            launch_last = last_q;
                        end
                    end else begin
                        // Bytes 16..31 of a GDRAM line come from the lower half (row y+32)
                        idx_d   = idx_q + 1'b1;
                        go      = 1'b1;
                        go_rs   = 1'b1;
                        go_rd   = 1'b1;
                        go_addr = {idx_d[4], line_q, idx_d[3:0]};
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_PWR_WAIT;
        endcase
        if (launch) begin
            go      = 1'b1;
            go_cmd  = CMD_ADDR | {3'b000, launch_y};
            line_d  = launch_y;
            last_d  = launch_last;
            state_d = ST_SET_Y;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PWR_WAIT;
            pwr_cnt_q   <= '0;
            idx_q       <= '0;
            line_q      <= '0;
            last_q      <= '0;
            init_done_q <= 1'b0;
            fdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwr_cnt_q   <= pwr_cnt_d;
            idx_q       <= idx_d;
            line_q      <= line_d;
            last_q      <= last_d;
            init_done_q <= init_done_q | init_set;
            fdone_q     <= fdone_set;
        end
    end

    // Bus datapath: rs/command and read strobe at slot start, read data lands one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q     <= 1'b0;
            dat_q    <= '0;
            rd_en_q  <= 1'b0;
            rd_dly_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            rd_en_q  <= go && go_rd;
            rd_dly_q <= rd_en_q;
            if (go) begin
                rs_q <= go_rs;
                if (go_rd) begin
                    addr_q <= go_addr;
                end else begin
                    dat_q <= go_cmd;
                end
            end
            if (rd_dly_q) begin
                dat_q <= fb_data;
            end
        end
    end

endmodule

// File: tb/tb_lcd12864_gfx_refresh.sv
// Self-checking bench for lcd12864_gfx_refresh with a bus-level reference model.
`timescale 1ns/1ps
module tb_lcd12864_gfx_refresh;
    localparam int CMD_CYCLES = 8;
    localparam int EN_SETUP   = 2;
    localparam int EN_WIDTH   = 3;
    localparam int CLR_CYCLES = 20;
    localparam int PWR_CYCLES = 50;
    localparam int INIT_DONE_AT = PWR_CYCLES + 6 * CMD_CYCLES + CLR_CYCLES;
    localparam int FULL_FRAME   = 1088 * CMD_CYCLES;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [4:0] line_first = '0;
    logic [4:0] line_last = '0;
    logic       busy, init_done, frame_done, fb_rd_en;
    logic [9:0] fb_addr;
    logic [7:0] fb_data = '0;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_dat;

    lcd12864_gfx_refresh #(
        .CMD_CYCLES(CMD_CYCLES),
        .EN_SETUP  (EN_SETUP),
        .EN_WIDTH  (EN_WIDTH),
        .CLR_CYCLES(CLR_CYCLES),
        .PWR_CYCLES(PWR_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .line_first(line_first),
        .line_last (line_last),
        .busy      (busy),
        .init_done (init_done),
        .frame_done(frame_done),
        .fb_rd_en  (fb_rd_en),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_dat   (lcd_dat)
    );

    always #5 clk = ~clk;

    logic [7:0] fb [1024];
    logic [7:0] init_bytes [7] = '{8'h30, 8'h30, 8'h0C, 8'h01, 8'h06, 8'h34, 8'h36};

    // Framebuffer RAM model: one-cycle read latency
    always @(posedge clk) if (fb_rd_en) fb_data <= fb[fb_addr];

    int cyc = 0;
    // Free-running cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] mon_q[$];
    int         mon_t[$];
    int         fd_q[$];
    int         viol = 0;
    int         en_w = 0;
    logic       en_prev = 1'b0;
    logic [8:0] held = '0;

    // Bus monitor: logs {rs,dat} at each lcd_en rise, frame_done times, and pulse-shape errors
    always @(negedge clk) begin
        if (frame_done) fd_q.push_back(cyc);
        if (lcd_en) begin
            if (!en_prev) begin
                mon_q.push_back({lcd_rs, lcd_dat});
                mon_t.push_back(cyc);
                held = {lcd_rs, lcd_dat};
                en_w = 1;
            end else begin
                en_w++;
                if ({lcd_rs, lcd_dat} != held) viol++;
            end
        end else if (en_prev && en_w != EN_WIDTH) begin
            viol++;
        end
        en_prev = lcd_en;
    end

    int total = 0;
    int bad = 0;
    int mon_b = 0, fd_b = 0, viol_b = 0, t0 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic mark_mon();
        mon_b  = mon_q.size();
        fd_b   = fd_q.size();
        viol_b = viol;
    endtask

    // Release reset and check the power-on wait plus init command stream
    task automatic do_init();
        int t;
        @(negedge clk);
        mark_mon();
        rst_n = 1'b1;
        t0 = cyc;
        repeat (INIT_DONE_AT - 1) @(negedge clk);
        chk("init_done_early", init_done, 1'b0);
        chk("busy_in_init", busy, 1'b1);
        @(negedge clk);
        chk("init_done", init_done, 1'b1);
`ifdef LCD12864_AUTO_REFRESH_EN
        chk("busy_after_init", busy, 1'b1);
`else
        chk("busy_after_init", busy, 1'b0);
`endif
        chk("init_cmd_count", mon_q.size() - mon_b, 7);
        t = PWR_CYCLES + EN_SETUP;
        for (int i = 0; i < 7 && mon_b + i < mon_q.size(); i++) begin
            chk($sformatf("init_cmd[%0d]", i), mon_q[mon_b + i], {1'b0, init_bytes[i]});
            chk($sformatf("init_time[%0d]", i), mon_t[mon_b + i] - t0, t);
            t += (i == 3) ? CLR_CYCLES : CMD_CYCLES;
        end
        chk("init_en_shape", viol - viol_b, 0);
    endtask

    // One frame request checked against the expected GDRAM write stream
    task automatic run_frame(input int first, input int last, input int extra_at);
        logic [8:0] exp_q[$];
        int nslots, fd_rel, c0, nmon;
        for (int y = first; y <= last; y++) begin
            exp_q.push_back({1'b0, 8'h80 | 8'(y)});
            exp_q.push_back(9'h080);
            for (int b = 0; b < 16; b++) exp_q.push_back({1'b1, fb[y * 16 + b]});
            for (int b = 0; b < 16; b++) exp_q.push_back({1'b1, fb[(y + 32) * 16 + b]});
        end
        nslots = exp_q.size();
        fd_rel = (nslots == 0) ? 1 : 1 + nslots * CMD_CYCLES;
        @(negedge clk);
        mark_mon();
        chk("busy_before_start", busy, 1'b0);
        line_first = 5'(first);
        line_last  = 5'(last);
        start = 1'b1;
        c0 = cyc;
        for (int i = 1; i <= fd_rel + 24; i++) begin
            @(negedge clk);
            start = (i == extra_at);
            if (i == extra_at) begin
                line_first = 5'd0;
                line_last  = 5'd0;
            end
            if (i == 1) chk("busy_after_start", busy, nslots != 0);
            if (i == fd_rel) begin
                chk("frame_done_pulse", frame_done, 1'b1);
                chk("busy_at_done", busy, 1'b0);
            end
        end
        start = 1'b0;
        nmon = mon_q.size() - mon_b;
        chk("frame_done_count", fd_q.size() - fd_b, 1);
        if (fd_q.size() > fd_b) chk("frame_done_time", fd_q[fd_b] - c0, fd_rel);
        chk("en_pulses", nmon, nslots);
        for (int k = 0; k < nslots && k < nmon; k++)
            chk($sformatf("bus[%0d..%0d][%0d]", first, last, k), mon_q[mon_b + k], exp_q[k]);
        if (nslots > 0 && nmon > 0) chk("first_en_time", mon_t[mon_b] - c0, 1 + EN_SETUP);
        chk("en_shape", viol - viol_b, 0);
    endtask

    initial begin
        int n, f, l;
        for (int a = 0; a < 1024; a++) fb[a] = 8'(a);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b1);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_fb_rd_en", fb_rd_en, 1'b0);
        chk("rst_fb_addr", fb_addr, 10'd0);
        chk("rst_lcd_rs", lcd_rs, 1'b0);
        chk("rst_lcd_rw", lcd_rw, 1'b0);
        chk("rst_lcd_en", lcd_en, 1'b0);
        chk("rst_lcd_dat", lcd_dat, 8'h00);
        do_init();
`ifdef LCD12864_AUTO_REFRESH_EN
        repeat (3 * FULL_FRAME + 20) @(negedge clk);
        chk("auto_fd_count", fd_q.size() - fd_b, 3);
        if (fd_q.size() > fd_b) chk("auto_fd_first", fd_q[fd_b] - t0, INIT_DONE_AT + FULL_FRAME);
        for (int k = fd_b + 1; k < fd_q.size(); k++)
            chk("auto_fd_period", fd_q[k] - fd_q[k - 1], FULL_FRAME);
        chk("auto_busy", busy, 1'b1);
`else
        run_frame(0, 31, 0);
        run_frame(5, 5, 50);
        run_frame(7, 3, 1);
        for (int a = 0; a < 1024; a++) fb[a] = 8'($urandom);
        run_frame(29, 31, 0);
        for (int r = 0; r < 3; r++) begin
            f = int'($urandom_range(0, 31));
            l = f + int'($urandom_range(0, 3));
            if (l > 31) l = 31;
            run_frame(f, l, int'($urandom_range(2, 200)));
        end
        f = int'($urandom_range(8, 31));
        run_frame(f, int'($urandom_range(0, 7)), 0);

        // Reset in the middle of a data slot
        @(negedge clk);
        line_first = 5'd0;
        line_last  = 5'd31;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        n = 0;
        while (!lcd_en && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_en", lcd_en, 1'b1);
        chk("pre_reset_rs", lcd_rs, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_lcd_en", lcd_en, 1'b0);
        chk("mid_rst_lcd_dat", lcd_dat, 8'h00);
        chk("mid_rst_busy", busy, 1'b1);
        chk("mid_rst_init_done", init_done, 1'b0);
        chk("mid_rst_fb_rd_en", fb_rd_en, 1'b0);
        chk("mid_rst_lcd_rs", lcd_rs, 1'b0);
        repeat (3) @(negedge clk);
        do_init();
        run_frame(5, 5, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd12864_gfx_refresh.md
# lcd12864_gfx_refresh

Parametrised ST7920 128x64 graphic-mode controller for the 8-bit parallel bus, write-only. Runs the power-on and init command sequence, then copies a 1024-byte monochrome framebuffer into GDRAM on request, or continuously, over a caller-selected range of GDRAM lines. Sits between a framebuffer RAM read port and the LCD pins. Per-byte timing and enable-pulse timing are generated from `clk` by parameters.

## Interface
- `CMD_CYCLES`, 3600: clk cycles per bus slot (one byte or command); 72 us at 50 MHz.
- `EN_SETUP`, 4: slot cycle at which `lcd_en` rises; must be ≥2.
- `EN_WIDTH`, 25: `lcd_en` high time in cycles; `EN_SETUP+EN_WIDTH < CMD_CYCLES`.
- `CLR_CYCLES`, 80000: slot length used for the clear command (0x01).
- `PWR_CYCLES`, 2000000: power-on wait before the first command.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle frame request; ignored unless idle.
- `line_first`, `line_last` in 5: inclusive GDRAM line range 0..31, sampled on accepted `start`.
- `busy` out 1: high from reset until init completes, and while a frame is in progress.
- `init_done` out 1: sticky high once init completes.
- `frame_done` out 1: one-cycle pulse at frame end.
- `fb_rd_en` out 1: framebuffer read strobe.
- `fb_addr` out 10: byte address, row*16 + column byte.
- `fb_data` in 8: read data, valid exactly 1 cycle after `fb_rd_en`. MSB is the leftmost pixel.
- `lcd_rs`, `lcd_rw`, `lcd_en` out 1: ST7920 control. `lcd_rw` is tied 0.
- `lcd_dat` out 8: ST7920 data bus.

## Operation
- States: PWR_WAIT → INIT → IDLE → SET_Y → SET_X → DATA → (SET_Y | DONE) → IDLE.
- PWR_WAIT: `PWR_CYCLES` cycles with no bus activity.
- INIT: seven command slots (rs=0): 0x30, 0x30, 0x0C, 0x01, 0x06, 0x34, 0x36. The 0x01 slot lasts `CLR_CYCLES`.
- After INIT: `init_done`=1, then IDLE.
- Accepted `start` (in IDLE only) latches the line range and sets `busy`.
- If `line_first > line_last`: go straight to DONE with no bus traffic.
- For each line y from `line_first` to `line_last`:
  - SET_Y: cmd 0x80|y.
  - SET_X: cmd 0x80.
  - DATA: 32 data slots (rs=1). Bytes 0..15 come from fb row y (`fb_addr` = y*16 + b). Bytes 16..31 come from fb row y+32 (`fb_addr` = (y+32)*16 + b−16). This relies on the GDRAM auto-increment across horizontal words 0..15.
- DONE: pulse `frame_done`, drop `busy`, return to IDLE.
- A full frame (0..31) is 64 command slots + 1024 data slots.
- Line counter is 5 bits. The last-line compare is done before increment, so `line_last`=31 never wraps to 0.

## Timing
- Slot cycle counter c = 0..CMD_CYCLES−1.
  - c=0: `lcd_rs` and command data (`lcd_dat`) driven. Data slots assert `fb_rd_en` for 1 cycle with `fb_addr` valid.
  - c=1: `fb_data` registered onto `lcd_dat`.
  - c=`EN_SETUP`: `lcd_en` rises.
  - c=`EN_SETUP+EN_WIDTH`: `lcd_en` falls.
  - `lcd_rs`/`lcd_dat` are held until the next slot's c=0.
- `lcd_en` and `lcd_dat` are registered outputs; no glitches.
- First slot of a frame starts 1 cycle after the accepted `start`.
- `frame_done` is asserted the cycle after the final slot's last cycle. `busy` falls in that same cycle.
- Reset values: `busy`=1, `init_done`=0, `frame_done`=0, `fb_rd_en`=0, `fb_addr`=0, `lcd_rs`=0, `lcd_en`=0, `lcd_dat`=0x00; state PWR_WAIT.
- `rst_n` low mid-frame: all outputs go to reset values immediately. After release, the full power-on + init sequence repeats.
- `start` during PWR_WAIT/INIT/frame: dropped, not queued.
- `start` in the same cycle as `frame_done`: dropped, because the block is not yet in IDLE.

## Configuration
- `LCD12864_AUTO_REFRESH_EN` defined:
  - After `init_done`, frames of lines 0..31 run back-to-back without `start`.
  - `frame_done` still pulses once per frame.
  - `start`, `line_first`, `line_last` are ignored; `busy` stays 1.
- Undefined: one frame per accepted `start`, as described above.

## Structure
- Package `lcd12864_pkg` holds:
  - state enum;
  - init command constants (`CMD_BASIC`=0x30, `CMD_DISP_ON`=0x0C, `CMD_CLEAR`=0x01, `CMD_ENTRY`=0x06, `CMD_EXT`=0x34, `CMD_GFX_ON`=0x36, `CMD_ADDR`=0x80);
  - geometry constants (`GD_LINES`=32, `GD_BYTES_PER_LINE`=32, `FB_BYTES`=1024).
- Sub-module `lcd12864_bus_slot`: slot timer plus `lcd_en` pulse generator. Inputs: `go`, `long_slot`. Output: `slot_end`. Parameterised by the timing parameters.

## Test plan
Bench parameters: `CMD_CYCLES`=8, `EN_SETUP`=2, `EN_WIDTH`=3, `CLR_CYCLES`=20, `PWR_CYCLES`=50. Framebuffer byte[a] = a[7:0].
- Reset release → 50 quiet cycles, then bus bytes 30,30,0C,01,06,34,36 with rs=0. The 01 `lcd_en` pulse is followed by a 20-cycle slot. `init_done`=1 after 50+6*8+20 cycles.
- `start`, lines 0..31 → 1088 slots; `frame_done` after 8704 cycles. Line 0 sends 80,80 then data 00..0F, 00..0F (addr 512..527 low bytes). Line 31 sends 9F,80.
- `start`, lines 5..5 → exactly 34 `lcd_en` pulses. Data = fb[80..95], fb[592..607].
- `start` with `line_first`=7, `line_last`=3 → `frame_done` 1 cycle later, zero `lcd_en` pulses. Second `start` pulse while busy → ignored, single `frame_done`.
- `rst_n` low mid-DATA → `lcd_en`/`lcd_dat`/`busy` at reset values the same cycle. Power-on wait + init repeat.
- With `LCD12864_AUTO_REFRESH_EN` → consecutive `frame_done` pulses exactly 8704 cycles apart with no `start`.
